// File: rtl/ps2_scancode_rx_fifo.sv
// PS/2 keyboard scancode receiver: sync/filter, 11-bit deframing, E0/F0 folding, show-ahead FIFO.
// Define PS2_RX_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYC cycles (pulses to_err_o).
module ps2_scancode_rx_fifo #(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rx_en,
  input  logic             rd_i,
  output logic [7:0]       code_o,
  output logic             brk_o,
  output logic             ext_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [FIFO_AW:0] count_o,
  output logic             par_err_o,
  output logic             frm_err_o,
  output logic             ovf_o,
  output logic             to_err_o
);
  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned FiltW = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_s, data_s;
  logic             filt_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             accept, fall;
  state_e           state_q, state_d;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic             par_q, ext_q, brk_q;
  logic             stop_fall, par_bad, frm_bad, frame_ok, push_req, timeout;
  logic             par_err_q, frm_err_q, ovf_q;
  logic [9:0]       mem [Depth];
  logic [9:0]       head;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic             full, do_pop, do_push;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end
  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // A new level is taken once it has been seen on FILT_LEN consecutive samples.
  assign accept = (clk_s != filt_q) && (filt_cnt_q == FiltW'(FILT_LEN - 1));
  assign fall   = accept && filt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_s == filt_q) begin
      filt_cnt_q <= '0;
    end else if (accept) begin
      filt_q     <= clk_s;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = StIdle;
    end else if (fall) begin
      unique case (state_q)
        StIdle:   if (rx_en && !data_s) state_d = StData;
        StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    stop_fall = fall && (state_q == StStop);
    par_bad   = stop_fall && !(^{shift_q, par_q});
    frm_bad   = stop_fall && !par_bad && !data_s;
    frame_ok  = stop_fall && !par_bad && data_s;
    push_req  = frame_ok && (shift_q != 8'hE0) && (shift_q != 8'hF0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      par_err_q <= par_bad;
      frm_err_q <= frm_bad;
      if (fall) begin
        if (state_q == StIdle) bit_cnt_q <= '0;
        if (state_q == StData) begin
          shift_q   <= {data_s, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        if (state_q == StParity) par_q <= data_s;
      end
      if (par_bad || frm_bad || timeout) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (frame_ok) begin
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  logic [ToW-1:0] to_cnt_q;
  logic           to_err_q;

  assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == ToW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= timeout;
      if (state_q == StIdle || fall || timeout) to_cnt_q <= '0;
      else                                      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
  assign to_err_o = to_err_q;
`else
  assign timeout  = 1'b0;
  assign to_err_o = 1'b0;
`endif

  // Pop is resolved first so a full FIFO can accept a push on the same edge.
  assign full    = (count_q == (FIFO_AW + 1)'(Depth));
  assign do_pop  = rd_i && (count_q != '0);
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= {ext_q, brk_q, shift_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= push_req && full && !rd_i;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    head      = mem[rd_ptr_q];
    empty_o   = (count_q == '0);
    full_o    = full;
    count_o   = count_q;
    code_o    = empty_o ? 8'h00 : head[7:0];
    brk_o     = !empty_o && head[8];
    ext_o     = !empty_o && head[9];
    par_err_o = par_err_q;
    frm_err_o = frm_err_q;
    ovf_o     = ovf_q;
  end
endmodule

// File: tb/tb_ps2_scancode_rx_fifo.sv
// Randomized bench for ps2_scancode_rx_fifo with a frame-level queue model and directed cases.
module tb_ps2_scancode_rx_fifo;
  localparam int unsigned FiltLen = 4;
  localparam int unsigned FifoAw  = 2;
  localparam int unsigned Depth   = 2 ** FifoAw;
  localparam int unsigned ToCyc   = 1000;

  logic clk = 0, rst = 1;
  logic ps2_clk = 1, ps2_data = 1, rx_en = 1, rd_i = 0;
  logic [7:0] code_o;
  logic brk_o, ext_o, empty_o, full_o, par_err_o, frm_err_o, ovf_o, to_err_o;
  logic [FifoAw:0] count_o;

  ps2_scancode_rx_fifo #(
    .FILT_LEN(FiltLen), .FIFO_AW(FifoAw), .TIMEOUT_CYC(ToCyc)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx_en(rx_en),
    .rd_i(rd_i), .code_o(code_o), .brk_o(brk_o), .ext_o(ext_o), .empty_o(empty_o),
    .full_o(full_o), .count_o(count_o), .par_err_o(par_err_o), .frm_err_o(frm_err_o),
    .ovf_o(ovf_o), .to_err_o(to_err_o)
  );

  always #10 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0;
  logic [9:0] q[$];
  bit m_ext = 0, m_brk = 0;
  int par_exp = 0, frm_exp = 0, ovf_exp = 0, to_exp = 0;
  int par_seen = 0, frm_seen = 0, ovf_seen = 0, to_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (par_err_o) par_seen++;
    if (frm_err_o) frm_seen++;
    if (ovf_o)     ovf_seen++;
    if (to_err_o)  to_seen++;
  end

  // Compare process: DUT head/status against the model whenever the model is current.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("empty", empty_o, q.size() == 0);
      check("full", full_o, q.size() == Depth);
      check("count", count_o, q.size());
      if (q.size() != 0) begin
        check("head_code", code_o, q[0][7:0]);
        check("head_brk", brk_o, q[0][8]);
        check("head_ext", ext_o, q[0][9]);
      end else begin
        check("idle_code", code_o, 0);
      end
    end
  end

  task automatic model_frame(input logic [7:0] b, input bit perr, input bit ferr);
    if (perr) begin
      par_exp++; m_ext = 0; m_brk = 0;
    end else if (ferr) begin
      frm_exp++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (q.size() == Depth) ovf_exp++;
      else q.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check_pulses();
    check("par_err_pulses", par_seen, par_exp);
    check("frm_err_pulses", frm_seen, frm_exp);
    check("ovf_pulses", ovf_seen, ovf_exp);
    check("to_err_pulses", to_seen, to_exp);
  endtask

  // Data set mid-high, clock low 100 ns, period 200 ns.
  task automatic ps2_bit(input logic b);
    ps2_data = b; #50; ps2_clk = 0; #100; ps2_clk = 1; #50;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit perr, input bit ferr, input bit en_mid);
    bit en_start;
    en_start = rx_en;
    chk_en = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ perr);
    if (en_mid) rx_en = 1;
    ps2_bit(~ferr);
    ps2_data = 1;
    #400;
    if (en_start) model_frame(b, perr, ferr);
    check_pulses();
    chk_en = 1;
  endtask

  task automatic pop();
    @(posedge clk); #1;
    chk_en = 0; rd_i = 1;
    @(posedge clk); #1;
    rd_i = 0;
    if (q.size() != 0) void'(q.pop_front());
    chk_en = 1;
  endtask

  task automatic expect_head(input string name, input logic [7:0] c, input bit e, input bit b);
    @(negedge clk);
    check({name, "_code"}, code_o, c);
    check({name, "_ext"}, ext_o, e);
    check({name, "_brk"}, brk_o, b);
    check({name, "_empty"}, empty_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running want=finished at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int cyc;
    bit perr, ferr;
    #35;
    check("rst_empty", empty_o, 1);
    check("rst_count", count_o, 0);
    check("rst_code", code_o, 0);
    check("rst_full", full_o, 0);
    check("rst_pulses", {par_err_o, frm_err_o, ovf_o, to_err_o}, 0);
    @(posedge clk); #1 rst = 0;
    repeat (5) @(posedge clk);
    chk_en = 1;

    // Plain key
    send_frame(8'h31, 0, 0, 0);
    expect_head("t1", 8'h31, 0, 0);
    check("t1_count", count_o, 1);
    pop();
    // Parity error clears a pending break prefix
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h31, 1, 0, 0);
    @(negedge clk);
    check("t2_empty", empty_o, 1);
    check("t2_par_pulses", par_seen, 1);
    send_frame(8'h31, 0, 0, 0);
    expect_head("t2", 8'h31, 0, 0);
    pop();
    // Prefix folding
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h31, 0, 0, 0);
    expect_head("t3a", 8'h31, 0, 1);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    @(negedge clk);
    check("t3_count", count_o, 2);
    pop();
    expect_head("t3b", 8'h75, 1, 1);
    pop();
    // Fill and overflow
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 0, 0, 0);
      @(negedge clk);
      if (i == 3) check("t4_full", full_o, 1);
    end
    check("t4_count", count_o, 4);
    check("t4_ovf_pulses", ovf_seen, 1);
    for (int i = 0; i < 4; i++) begin
      expect_head("t4_pop", 8'h10 + 8'(i), 0, 0);
      pop();
    end
    @(negedge clk);
    check("t4_empty", empty_o, 1);
    // Framing error, parity error wins when both are bad
    send_frame(8'h31, 0, 1, 0);
    send_frame(8'h31, 1, 1, 0);
    check("frm_pulses", frm_seen, 1);
    // Receive enable
    rx_en = 0;
    send_frame(8'h31, 0, 0, 0);
    rx_en = 0;
    send_frame(8'h1C, 0, 0, 1);
    @(negedge clk);
    check("t5_empty", empty_o, 1);
    send_frame(8'h1C, 0, 0, 0);
    expect_head("t5", 8'h1C, 0, 0);
    pop();

`ifdef PS2_RX_TIMEOUT_EN
    chk_en = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    cyc = 0;
    while (!to_err_o && cyc < 1300) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_to_seen", to_err_o, 1);
    check("t6_to_window", (cyc >= 990 && cyc <= 1012), 1);
    to_exp++;
    m_ext = 0; m_brk = 0;
    #200;
    check_pulses();
    chk_en = 1;
    send_frame(8'h31, 0, 0, 0);
    expect_head("t6", 8'h31, 0, 0);
    pop();
`endif

    // Reset mid-frame with stored content
    send_frame(8'h22, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    chk_en = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(posedge clk); #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    q.delete(); m_ext = 0; m_brk = 0;
    repeat (20) @(posedge clk);
    check("rst_mid_empty", empty_o, 1);
    check_pulses();
    chk_en = 1;
    send_frame(8'h31, 0, 0, 0);
    expect_head("after_rst", 8'h31, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      perr = ($urandom_range(0, 9) == 0);
      ferr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) begin
        rx_en = 0;
        send_frame(b, perr, 0, 1);
      end else begin
        send_frame(b, perr, ferr, 0);
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) pop();
    end
    while (q.size() != 0) pop();
    pop();
    @(negedge clk);
    check("final_empty", empty_o, 1);
    check_pulses();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
